// File: rtl/fifo_depth_n.sv
// rtl/fifo_depth_n.sv - DEPTH-entry circular-buffer FIFO with ENA/RDY handshakes
//
// Purpose : stores WIDTH-bit entries in a DEPTH-entry ring. The head entry is
//           presented combinationally from registered state, so an entry
//           enqueued in cycle t becomes visible in cycle t+1 (no bypass).
// Ports   : CLK            clock, all state changes on its rising edge
//           nRST           synchronous active-low reset (clears count, pointers, storage)
//           in_enq__ENA    enqueue request
//           in_enq_v       enqueue data (WIDTH)
//           in_enq__RDY    an enqueue may be accepted this cycle
//           out_deq__ENA   dequeue request
//           out_deq__RDY   a dequeue may be accepted this cycle
//           out_first      head entry data (WIDTH)
//           out_first__RDY out_first is valid
//           count          occupancy 0..DEPTH ($clog2(DEPTH)+1 bits)
// Option  : FIFO_DEPTH_N_PIPELINE_EN - when defined, a full FIFO accepts an
//           enqueue in the same cycle as a dequeue (in_enq__RDY also asserted
//           by out_deq__ENA).
module fifo_depth_n #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       in_enq__ENA,
  input  logic [WIDTH-1:0]           in_enq_v,
  output logic                       in_enq__RDY,
  input  logic                       out_deq__ENA,
  output logic                       out_deq__RDY,
  output logic [WIDTH-1:0]           out_first,
  output logic                       out_first__RDY,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  logic not_empty;
  logic enq_fire;
  logic deq_fire;

  assign not_empty      = (count_q != '0);
  assign out_deq__RDY   = not_empty;
  assign out_first__RDY = not_empty;
  assign out_first      = mem_q[rd_ptr_q];
  assign count          = count_q;

`ifdef FIFO_DEPTH_N_PIPELINE_EN
  // When full, a simultaneous dequeue frees the head slot; since the write
  // pointer equals the read pointer when full, the new entry lands there.
  assign in_enq__RDY = (count_q != FULL_COUNT) | out_deq__ENA;
`else
  assign in_enq__RDY = (count_q != FULL_COUNT);
`endif

  // Requests only take effect when the matching RDY is high.
  assign enq_fire = in_enq__ENA & in_enq__RDY;
  assign deq_fire = out_deq__ENA & out_deq__RDY;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (enq_fire) begin
      mem_d[wr_ptr_q] = in_enq_v;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end

    // Dequeue only moves the pointer; the vacated slot keeps its old data.
    if (deq_fire) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    unique case ({enq_fire, deq_fire})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_fifo_depth_n.sv
// tb/tb_fifo_depth_n.sv - directed vector bench for fifo_depth_n (WIDTH=8, DEPTH=4)
module tb_fifo_depth_n;

  logic       CLK;
  logic       nRST;
  logic       in_enq__ENA;
  logic [7:0] in_enq_v;
  logic       in_enq__RDY;
  logic       out_deq__ENA;
  logic       out_deq__RDY;
  logic [7:0] out_first;
  logic       out_first__RDY;
  logic [2:0] count;

  fifo_depth_n #(.WIDTH(8), .DEPTH(4)) dut (
    .CLK            (CLK),
    .nRST           (nRST),
    .in_enq__ENA    (in_enq__ENA),
    .in_enq_v       (in_enq_v),
    .in_enq__RDY    (in_enq__RDY),
    .out_deq__ENA   (out_deq__ENA),
    .out_deq__RDY   (out_deq__RDY),
    .out_first      (out_first),
    .out_first__RDY (out_first__RDY),
    .count          (count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic       nrst;
    logic       enq;
    logic [7:0] v;
    logic       deq;
    logic [2:0] exp_count;
    logic [7:0] exp_first;
    logic       exp_in_rdy;
    logic       exp_out_rdy;
  } vec_t;

  vec_t vecs[$];
  int   n_vec;
  int   n_bad;

  function automatic void add(input logic nrst, input logic enq, input logic [7:0] v,
                              input logic deq, input logic [2:0] c, input logic [7:0] f,
                              input logic ir, input logic orr);
    vec_t x;
    x.nrst = nrst; x.enq = enq; x.v = v; x.deq = deq;
    x.exp_count = c; x.exp_first = f; x.exp_in_rdy = ir; x.exp_out_rdy = orr;
    vecs.push_back(x);
  endfunction

  task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic idle();
    nRST = 1'b1; in_enq__ENA = 1'b0; out_deq__ENA = 1'b0; in_enq_v = 8'h00;
  endtask

  task automatic apply(input vec_t x, input int idx);
    nRST = x.nrst; in_enq__ENA = x.enq; in_enq_v = x.v; out_deq__ENA = x.deq;
    @(posedge CLK);
    #1;
    idle();
    #1;
    check("count", idx, {5'b0, count}, {5'b0, x.exp_count});
    check("out_first", idx, out_first, x.exp_first);
    check("in_enq__RDY", idx, {7'b0, in_enq__RDY}, {7'b0, x.exp_in_rdy});
    check("out_deq__RDY", idx, {7'b0, out_deq__RDY}, {7'b0, x.exp_out_rdy});
    check("out_first__RDY", idx, {7'b0, out_first__RDY}, {7'b0, x.exp_out_rdy});
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    nRST = 1'b0; in_enq__ENA = 1'b0; out_deq__ENA = 1'b0; in_enq_v = 8'h00;

    //   nrst enq  v      deq  cnt  first  ir  or
    // reset
    add(0, 0, 8'h00, 0, 3'd0, 8'h00, 1, 0);
    // fill
    add(1, 1, 8'h11, 0, 3'd1, 8'h11, 1, 1);
    add(1, 1, 8'h22, 0, 3'd2, 8'h11, 1, 1);
    add(1, 1, 8'h33, 0, 3'd3, 8'h11, 1, 1);
    add(1, 1, 8'h44, 0, 3'd4, 8'h11, 0, 1);
    // enqueue while full is ignored
    add(1, 1, 8'h99, 0, 3'd4, 8'h11, 0, 1);
    // drain in order; storage is not cleared so head reads old 0x11 when empty
    add(1, 0, 8'h00, 1, 3'd3, 8'h22, 1, 1);
    add(1, 0, 8'h00, 1, 3'd2, 8'h33, 1, 1);
    add(1, 0, 8'h00, 1, 3'd1, 8'h44, 1, 1);
    add(1, 0, 8'h00, 1, 3'd0, 8'h11, 1, 0);
    // dequeue while empty is ignored
    add(1, 0, 8'h00, 1, 3'd0, 8'h11, 1, 0);
    // empty with both requests: enqueue only
    add(1, 1, 8'h5A, 1, 3'd1, 8'h5A, 1, 1);
    // count held at 2 with simultaneous traffic, crossing the wrap
    add(1, 1, 8'h01, 0, 3'd2, 8'h5A, 1, 1);
    add(1, 1, 8'h02, 1, 3'd2, 8'h01, 1, 1);
    add(1, 1, 8'h03, 1, 3'd2, 8'h02, 1, 1);
    add(1, 1, 8'h04, 1, 3'd2, 8'h03, 1, 1);
    add(1, 1, 8'h05, 1, 3'd2, 8'h04, 1, 1);
    add(1, 1, 8'h06, 1, 3'd2, 8'h05, 1, 1);
    add(1, 1, 8'h07, 1, 3'd2, 8'h06, 1, 1);
    add(1, 1, 8'h08, 1, 3'd2, 8'h07, 1, 1);
    add(1, 1, 8'h09, 1, 3'd2, 8'h08, 1, 1);
    add(1, 1, 8'h0A, 1, 3'd2, 8'h09, 1, 1);
    // fill to full: contents 09,0A,0B,0C
    add(1, 1, 8'h0B, 0, 3'd3, 8'h09, 1, 1);
    add(1, 1, 8'h0C, 0, 3'd4, 8'h09, 0, 1);
`ifdef FIFO_DEPTH_N_PIPELINE_EN
    // full with both requests: both accepted, A5 goes to the tail
    add(1, 1, 8'hA5, 1, 3'd4, 8'h0A, 0, 1);
    add(1, 0, 8'h00, 1, 3'd3, 8'h0B, 1, 1);
    add(1, 0, 8'h00, 1, 3'd2, 8'h0C, 1, 1);
    add(1, 0, 8'h00, 1, 3'd1, 8'hA5, 1, 1);
    add(1, 0, 8'h00, 1, 3'd0, 8'h0A, 1, 0);
`else
    // full with both requests: dequeue only, A5 dropped
    add(1, 1, 8'hA5, 1, 3'd3, 8'h0A, 1, 1);
    add(1, 0, 8'h00, 1, 3'd2, 8'h0B, 1, 1);
    add(1, 0, 8'h00, 1, 3'd1, 8'h0C, 1, 1);
    add(1, 0, 8'h00, 1, 3'd0, 8'h09, 1, 0);
`endif
    // count=3 then reset with enqueue request high
    add(1, 1, 8'h31, 0, 3'd1, 8'h31, 1, 1);
    add(1, 1, 8'h32, 0, 3'd2, 8'h31, 1, 1);
    add(1, 1, 8'h33, 0, 3'd3, 8'h31, 1, 1);
    add(0, 1, 8'h77, 0, 3'd0, 8'h00, 1, 0);
    add(1, 1, 8'h66, 0, 3'd1, 8'h66, 1, 1);

    @(posedge CLK);
    #1;
    foreach (vecs[i]) apply(vecs[i], i);

    // No bypass: a new entry is not visible before the edge that stores it.
    nRST = 1'b0;
    @(posedge CLK);
    #1;
    nRST = 1'b1; in_enq__ENA = 1'b1; in_enq_v = 8'hE1;
    #1;
    check("nobypass_rdy", 100, {7'b0, out_first__RDY}, 8'h00);
    check("nobypass_data", 100, out_first, 8'h00);
    @(posedge CLK);
    #1;
    idle();
    #1;
    check("after_enq_data", 101, out_first, 8'hE1);

    // Fill, then probe in_enq__RDY dependence on out_deq__ENA while full.
    for (int k = 0; k < 3; k++) begin
      in_enq__ENA = 1'b1; in_enq_v = 8'hF0 + 8'(k);
      @(posedge CLK);
      #1;
    end
    idle();
    #1;
    check("full_count", 102, {5'b0, count}, 8'd4);
    check("full_rdy_nodeq", 103, {7'b0, in_enq__RDY}, 8'h00);
    out_deq__ENA = 1'b1;
    #1;
`ifdef FIFO_DEPTH_N_PIPELINE_EN
    check("full_rdy_deq", 104, {7'b0, in_enq__RDY}, 8'h01);
`else
    check("full_rdy_deq", 104, {7'b0, in_enq__RDY}, 8'h00);
`endif
    idle();
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/fifo_depth_n.md
FIFO_DEPTH_N -- requirements
Module: fifo_depth_n

Interface
REQ-001 SHALL have parameter WIDTH, default 256: data width in bits, >=1.
REQ-002 SHALL have parameter DEPTH, default 4: entry count, power of two, >=2.
REQ-003 SHALL have port CLK  input  1  clock; all state changes on rising edge.
REQ-004 SHALL have port nRST  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_enq__ENA  input  1  enqueue request.
REQ-006 SHALL have port in_enq_v  input  WIDTH  enqueue data.
REQ-007 SHALL have port in_enq__RDY  output  1  enqueue may be accepted this cycle.
REQ-008 SHALL have port out_deq__ENA  input  1  dequeue request.
REQ-009 SHALL have port out_deq__RDY  output  1  dequeue may be accepted this cycle.
REQ-010 SHALL have port out_first  output  WIDTH  head entry data.
REQ-011 SHALL have port out_first__RDY  output  1  out_first is valid.
REQ-012 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Function
REQ-013 SHALL store entries in a DEPTH-entry circular buffer with read/write pointers of $clog2(DEPTH) bits, wrapping DEPTH-1 -> 0 naturally.
REQ-014 SHALL qualify requests internally: enq fires = in_enq__ENA & in_enq__RDY; deq fires = out_deq__ENA & out_deq__RDY; an unqualified ENA changes no state.
REQ-015 SHALL, on enq fire, write in_enq_v at the write pointer and advance it by 1.
REQ-016 SHALL, on deq fire, advance the read pointer by 1; storage is not cleared.
REQ-017 SHALL update count: +1 on enq only, -1 on deq only, unchanged on both or neither.
REQ-018 SHALL drive out_deq__RDY = out_first__RDY = (count != 0).
REQ-019 SHALL drive in_enq__RDY = (count != DEPTH) when the REQ-025 option is compiled out.
REQ-020 SHALL drive out_first = storage[read pointer] combinationally from registered state; an entry enqueued in cycle t is visible at cycle t+1, never in cycle t (no bypass).
REQ-021 SHALL, when empty with both ENAs high, accept the enq only; count becomes 1.
REQ-022 SHALL, when full with both ENAs high (option off), accept the deq only; count becomes DEPTH-1.
REQ-023 SHALL preserve strict FIFO order across pointer wrap.

Reset
REQ-024 SHALL, while nRST is low at a rising edge, set count, both pointers and all storage to 0 regardless of ENAs; contents in flight are discarded; out_first reads 0 and all RDY outputs except in_enq__RDY are 0 after reset.

Configuration
REQ-025 SHALL support macro FIFO_DEPTH_N_PIPELINE_EN; when defined, in_enq__RDY = (count != DEPTH) | out_deq__ENA, and a full FIFO with both ENAs high accepts both, writing the new entry into the slot being freed, with count staying DEPTH; when undefined, REQ-019 and REQ-022 apply, and in_enq__RDY has no combinational dependence on out_deq__ENA.

Verification (WIDTH=8, DEPTH=4)
REQ-026 Bench SHALL cover: reset, then enq 0x11,0x22,0x33,0x44 on consecutive cycles -> count 1..4, in_enq__RDY=0 at count 4, out_first=0x11 throughout.
REQ-027 Bench SHALL cover: from full, 4 deqs -> out_first 0x11,0x22,0x33,0x44 in order, count 3..0, out_deq__RDY=0 at count 0.
REQ-028 Bench SHALL cover: 10 enqs interleaved with deqs, count held at 2 with simultaneous enq+deq -> data order preserved across pointer wrap.
REQ-029 Bench SHALL cover: empty FIFO, both ENAs high with data 0x5A -> count=1, next-cycle out_first=0x5A; full FIFO, both ENAs high with data 0xA5 -> option off: count=3, 0xA5 not stored; option on: count=4, 0xA5 stored at tail.
REQ-030 Bench SHALL cover: count=3, nRST low one cycle with in_enq__ENA high -> count=0, out_first=0, out_first__RDY=0, enq ignored.
